// File: rtl/module_calc_pkg.sv
// Shared types and constants for the calculator keypad entry controller.
package module_calc_pkg;

  typedef enum logic [2:0] {
    S_ENTRY_A = 3'd0,
    S_ENTRY_B = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_SHOW    = 3'd4
  } entry_state_t;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  localparam logic [1:0] DISP_A   = 2'd0;
  localparam logic [1:0] DISP_B   = 2'd1;
  localparam logic [1:0] DISP_RES = 2'd2;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/module_entry_ctrl_if.sv
// Keypad/arithmetic-unit side signals of the entry controller.
interface module_entry_ctrl_if #(
  parameter int NDIG = 3
);
  localparam int CNT_W = $clog2(NDIG + 1);

  logic                 key_valid;
  logic [3:0]           key_code;
  logic                 done;
  logic [4*NDIG-1:0]    op_a;
  logic [4*NDIG-1:0]    op_b;
  logic                 start;
  logic [1:0]           disp_sel;
  logic [CNT_W-1:0]     digit_cnt;
  logic                 ovf;
  logic                 err;

  modport master (
    output key_valid, key_code, done,
    input  op_a, op_b, start, disp_sel, digit_cnt, ovf, err
  );

  modport slave (
    input  key_valid, key_code, done,
    output op_a, op_b, start, disp_sel, digit_cnt, ovf, err
  );

endinterface

// File: rtl/module_entry_ctrl_bcd_shift_reg.sv
// NDIG-digit BCD operand register, shifted left one digit per accepted key.
module module_bcd_shift_reg #(
  parameter int NDIG = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         shift_en,
  input  logic [3:0]                   din,
  output logic [4*NDIG-1:0]            q,
  output logic [$clog2(NDIG+1)-1:0]    cnt,
  output logic                         full
);
  localparam int CNT_W = $clog2(NDIG + 1);

  assign full = (cnt == CNT_W'(NDIG));

  // clr together with shift_en restarts the operand with din as its first digit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      cnt <= '0;
    end else if (clr) begin
      q   <= shift_en ? {{(4*(NDIG-1)){1'b0}}, din} : '0;
      cnt <= shift_en ? CNT_W'(1) : '0;
    end else if (shift_en && !full) begin
      q   <= {q[4*NDIG-5:0], din};
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/module_entry_ctrl.sv
// Keypad entry controller: assembles two BCD operands, launches the
// arithmetic unit, waits for done with a timeout and sequences the display.
//
//   state     | meaning
//   ENTRY_A   | collecting digits of operand A
//   ENTRY_B   | collecting digits of operand B
//   START     | one-cycle launch of the arithmetic unit
//   WAIT      | waiting for done, keys ignored, timeout running
//   SHOW      | result displayed, next digit starts a new calculation
module module_entry_ctrl
  import module_calc_pkg::*;
#(
  parameter int NDIG    = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  module_entry_ctrl_if.slave   bus
);
  localparam int CNT_W = $clog2(NDIG + 1);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  entry_state_t       state, state_nxt;
  logic [TMR_W-1:0]   tmr, tmr_nxt;
  logic               err_q, err_nxt;
  logic               ovf_q, ovf_nxt;
  logic               a_clr, a_sh, b_clr, b_sh;
  logic [CNT_W-1:0]   a_cnt, b_cnt;
  logic               a_full, b_full;
  logic               key_digit, key_enter, key_clear;

  assign key_digit = bus.key_valid && is_digit(bus.key_code);
  assign key_enter = bus.key_valid && (bus.key_code == KEY_ENTER);
  assign key_clear = bus.key_valid && (bus.key_code == KEY_CLEAR);

  module_bcd_shift_reg #(.NDIG(NDIG)) u_op_a (
    .clk      (clk),
    .rst      (rst),
    .clr      (a_clr),
    .shift_en (a_sh),
    .din      (bus.key_code),
    .q        (bus.op_a),
    .cnt      (a_cnt),
    .full     (a_full)
  );

  module_bcd_shift_reg #(.NDIG(NDIG)) u_op_b (
    .clk      (clk),
    .rst      (rst),
    .clr      (b_clr),
    .shift_en (b_sh),
    .din      (bus.key_code),
    .q        (bus.op_b),
    .cnt      (b_cnt),
    .full     (b_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_ENTRY_A;
      tmr   <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      err_q <= err_nxt;
      ovf_q <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    err_nxt   = err_q;
    ovf_nxt   = 1'b0;
    a_clr     = 1'b0;
    a_sh      = 1'b0;
    b_clr     = 1'b0;
    b_sh      = 1'b0;
    case (state)
      S_ENTRY_A: begin
        if (key_clear) begin
          a_clr   = 1'b1;
          b_clr   = 1'b1;
          err_nxt = 1'b0;
        end else if (key_enter) begin
          state_nxt = S_ENTRY_B;
        end else if (key_digit) begin
          if (a_full) ovf_nxt = 1'b1;
          else        a_sh    = 1'b1;
        end
      end
      S_ENTRY_B: begin
        if (key_clear) begin
          a_clr     = 1'b1;
          b_clr     = 1'b1;
          err_nxt   = 1'b0;
          state_nxt = S_ENTRY_A;
        end else if (key_enter) begin
          state_nxt = S_START;
        end else if (key_digit) begin
          if (b_full) ovf_nxt = 1'b1;
          else        b_sh    = 1'b1;
        end
      end
      S_START: begin
        state_nxt = S_WAIT;
        tmr_nxt   = '0;
        err_nxt   = 1'b0;
      end
      S_WAIT: begin
        if (bus.done) begin
          state_nxt = S_SHOW;
        end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = S_SHOW;
        end else begin
          tmr_nxt = tmr + TMR_W'(1);
        end
      end
      S_SHOW: begin
        if (key_clear) begin
          a_clr     = 1'b1;
          b_clr     = 1'b1;
          err_nxt   = 1'b0;
          state_nxt = S_ENTRY_A;
        end else if (key_digit) begin
          // new calculation: digit becomes the first digit of A
          a_clr     = 1'b1;
          a_sh      = 1'b1;
          b_clr     = 1'b1;
          state_nxt = S_ENTRY_A;
        end
      end
      default: begin
        a_clr     = 1'b1;
        b_clr     = 1'b1;
        err_nxt   = 1'b0;
        tmr_nxt   = '0;
        state_nxt = S_ENTRY_A;
      end
    endcase
  end

  // decoded from state so an async reset drops start immediately
  always_comb begin
    bus.disp_sel = DISP_A;
    case (state)
      S_ENTRY_B, S_START, S_WAIT: bus.disp_sel = DISP_B;
      S_SHOW:                     bus.disp_sel = DISP_RES;
      default:                    bus.disp_sel = DISP_A;
    endcase
  end

  assign bus.start     = (state == S_START);
  assign bus.digit_cnt = (state == S_ENTRY_A) ? a_cnt : b_cnt;
  assign bus.ovf       = ovf_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_module_entry_ctrl.sv
// Directed bench for module_entry_ctrl with hand-computed expectations.
module tb_module_entry_ctrl;
  import module_calc_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   n_start;
  int   s0;

  module_entry_ctrl_if #(.NDIG(3)) bus ();

  module_entry_ctrl #(.NDIG(3), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.start) n_start++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] code);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_start  = 0;
    rst           = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.done      = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_op_a", 32'(bus.op_a), 32'h0);
    check_val("rst_op_b", 32'(bus.op_b), 32'h0);
    check_val("rst_cnt", 32'(bus.digit_cnt), 32'd0);
    check_val("rst_start", 32'(bus.start), 32'd0);
    check_val("rst_ovf", 32'(bus.ovf), 32'd0);
    check_val("rst_err", 32'(bus.err), 32'd0);
    check_val("rst_disp", 32'(bus.disp_sel), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 123 ENTER 45 ENTER, done a few cycles after start
    press(4'd1);
    check_val("a1_cnt", 32'(bus.digit_cnt), 32'd1);
    check_val("a1_op_a", 32'(bus.op_a), 32'h001);
    press(4'd2);
    press(4'd3);
    check_val("a123_op_a", 32'(bus.op_a), 32'h123);
    check_val("a123_cnt", 32'(bus.digit_cnt), 32'd3);
    press(4'hB);
    check_val("ignored_op_a", 32'(bus.op_a), 32'h123);
    check_val("ignored_disp", 32'(bus.disp_sel), 32'd0);
    press(KEY_ENTER);
    check_val("entb_disp", 32'(bus.disp_sel), 32'd1);
    check_val("entb_cnt", 32'(bus.digit_cnt), 32'd0);
    press(4'd4);
    press(4'd5);
    check_val("b45_op_b", 32'(bus.op_b), 32'h045);
    check_val("b45_cnt", 32'(bus.digit_cnt), 32'd2);
    s0 = n_start;
    press(KEY_ENTER);
    check_val("start_hi", 32'(bus.start), 32'd1);
    check_val("start_disp", 32'(bus.disp_sel), 32'd1);
    @(negedge clk);
    check_val("wait_start_lo", 32'(bus.start), 32'd0);
    @(negedge clk);
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    check_val("show_disp", 32'(bus.disp_sel), 32'd2);
    check_val("show_op_a", 32'(bus.op_a), 32'h123);
    check_val("show_op_b", 32'(bus.op_b), 32'h045);
    check_val("start_pulses", 32'(n_start - s0), 32'd1);

    // overflow on the fourth digit
    press(KEY_CLEAR);
    check_val("clr_disp", 32'(bus.disp_sel), 32'd0);
    check_val("clr_op_a", 32'(bus.op_a), 32'h0);
    check_val("clr_op_b", 32'(bus.op_b), 32'h0);
    press(4'd9);
    press(4'd8);
    press(4'd7);
    check_val("ovf_before", 32'(bus.ovf), 32'd0);
    press(4'd6);
    check_val("ovf_pulse", 32'(bus.ovf), 32'd1);
    check_val("ovf_op_a", 32'(bus.op_a), 32'h987);
    check_val("ovf_cnt", 32'(bus.digit_cnt), 32'd3);
    @(negedge clk);
    check_val("ovf_drop", 32'(bus.ovf), 32'd0);

    // empty operands, then timeout with no done
    press(KEY_CLEAR);
    press(KEY_ENTER);
    s0 = n_start;
    press(KEY_ENTER);
    check_val("empty_start", 32'(bus.start), 32'd1);
    check_val("empty_op_a", 32'(bus.op_a), 32'h0);
    check_val("empty_op_b", 32'(bus.op_b), 32'h0);
    @(negedge clk);
    repeat (15) @(negedge clk);
    check_val("to_err_early", 32'(bus.err), 32'd0);
    check_val("to_disp_early", 32'(bus.disp_sel), 32'd1);
    @(negedge clk);
    check_val("to_err", 32'(bus.err), 32'd1);
    check_val("to_disp", 32'(bus.disp_sel), 32'd2);
    check_val("to_pulses", 32'(n_start - s0), 32'd1);
    press(KEY_CLEAR);
    check_val("to_clr_err", 32'(bus.err), 32'd0);
    check_val("to_clr_disp", 32'(bus.disp_sel), 32'd0);

    // keys ignored in WAIT, then a digit in SHOW starts over
    press(4'd1);
    press(KEY_ENTER);
    press(4'd2);
    press(KEY_ENTER);
    @(negedge clk);
    press(KEY_CLEAR);
    press(4'd5);
    check_val("wait_op_a", 32'(bus.op_a), 32'h001);
    check_val("wait_op_b", 32'(bus.op_b), 32'h002);
    check_val("wait_disp", 32'(bus.disp_sel), 32'd1);
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    check_val("wait_show", 32'(bus.disp_sel), 32'd2);
    press(4'd7);
    check_val("new_op_a", 32'(bus.op_a), 32'h007);
    check_val("new_op_b", 32'(bus.op_b), 32'h0);
    check_val("new_cnt", 32'(bus.digit_cnt), 32'd1);
    check_val("new_disp", 32'(bus.disp_sel), 32'd0);

    // async reset in the START cycle
    press(KEY_ENTER);
    press(KEY_ENTER);
    check_val("ar_start_hi", 32'(bus.start), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("ar_start", 32'(bus.start), 32'd0);
    check_val("ar_disp", 32'(bus.disp_sel), 32'd0);
    check_val("ar_op_a", 32'(bus.op_a), 32'h0);
    check_val("ar_cnt", 32'(bus.digit_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
